fwd_clk_monitor: RTL and testbench

- Receive-side companion to the clock-forwarding top: observes a forwarded clock (asynchronous to the local clock) and decides whether it is present and toggling at the expected rate.
- Synchronises the forwarded clock and counts its rising edges over fixed windows of local clock cycles.
- Classifies each window as in-range or out-of-range and runs a lock/loss state machine.
- Sits at the far end of a forwarded-clock link; drives status for control logic.

---
 rtl/fwd_clk_monitor.sv | 184 ++++++++++++++++++
 tb/tb_fwd_clk_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fwd_clk_monitor
// Purpose  : Counts synchronised forwarded-clock edges per window and runs a
//            lock/loss FSM. Optional sticky loss flag: FWD_CLK_MON_STICKY_ERR_EN
// Revision : 1.0 - initial release
// ============================================================================
module fwd_clk_monitor #(
    parameter bit  bypass       = 1'b0,
    parameter int  WINDOW       = 256,
    parameter int  MIN_EDGES    = 60,
    parameter int  MAX_EDGES    = 68,
    parameter int  LOCK_WINDOWS = 4,
    localparam int CNT_W        = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fwd_clk,
    input  logic             enable,
    output logic             active,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] last_count,
    output logic             err_pulse,
    output logic             err_sticky
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  c_win_last = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [GOOD_W-1:0] c_lock     = GOOD_W'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic                w_rise;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic [CNT_W-1:0]    r_last;
    logic [CNT_W-1:0]    w_cnt_fin;
    logic [GOOD_W-1:0]   r_good;
    logic [GOOD_W-1:0]   w_good_nxt;
    logic [GOOD_W-1:0]   w_good_inc;
    logic                r_pulse;
    logic                w_pulse_nxt;
    logic                w_run;
    logic                w_win_end;
    logic                w_in_range;

    // Synchroniser runs regardless of enable so it is settled on entry to ACQUIRE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= fwd_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise     = r_s2 & ~r_s3;
    assign w_run      = enable && (r_state != S_IDLE);
    assign w_win_end  = w_run && (r_win_cnt == c_win_last);
    assign w_cnt_fin  = (w_rise && (r_edge_cnt != c_cnt_max)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_in_range = (32'(w_cnt_fin) >= 32'(MIN_EDGES)) && (32'(w_cnt_fin) <= 32'(MAX_EDGES));
    assign w_good_inc = r_good + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_last     <= '0;
        end else if (!w_run) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (w_win_end) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_last     <= w_cnt_fin;
        end else begin
            r_win_cnt  <= r_win_cnt + 1'b1;
            r_edge_cnt <= w_cnt_fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_good  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_pulse_nxt = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_good_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQUIRE;
                    w_good_nxt  = '0;
                end
                S_ACQUIRE: begin
                    if (w_win_end) begin
                        if (!w_in_range) begin
                            w_good_nxt = '0;
                        end else if (w_good_inc >= c_lock) begin
                            w_state_nxt = S_LOCKED;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt = w_good_inc;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_win_end && !w_in_range) begin
                        w_state_nxt = S_LOST;
                        w_pulse_nxt = ~bypass;
                    end
                end
                S_LOST: begin
                    if (w_win_end && w_in_range) begin
                        if (LOCK_WINDOWS == 1) begin
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_state_nxt = S_ACQUIRE;
                            w_good_nxt  = GOOD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

    // Bypass keeps counting but presents a permanently locked, error-free face
    assign active     = bypass ? (r_state != S_IDLE) : (r_state == S_LOCKED);
    assign state_o    = (bypass && (r_state != S_IDLE)) ? S_LOCKED : r_state;
    assign last_count = r_last;
    assign err_pulse  = r_pulse;

`ifdef FWD_CLK_MON_STICKY_ERR_EN
    logic r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (!enable) begin
            r_sticky <= 1'b0;
        end else if (w_pulse_nxt) begin
            r_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_sticky;
`else
    assign err_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_clk_monitor
// Purpose  : Self-checking bench for fwd_clk_monitor (normal and bypass builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_clk_monitor;

    localparam int WINDOW       = 64;
    localparam int MIN_EDGES    = 14;
    localparam int MAX_EDGES    = 18;
    localparam int LOCK_WINDOWS = 2;
    localparam int CNT_W        = $clog2(WINDOW + 1);
    localparam int VH           = 16384;
`ifdef FWD_CLK_MON_STICKY_ERR_EN
    localparam bit c_stk = 1'b1;
`else
    localparam bit c_stk = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             fwd_clk = 1'b0;
    logic             enable  = 1'b0;
    logic             active, active_b;
    logic [1:0]       state_o, state_o_b;
    logic [CNT_W-1:0] last_count, last_count_b;
    logic             err_pulse, err_pulse_b;
    logic             err_sticky, err_sticky_b;

    always #5 clk = ~clk;

    fwd_clk_monitor #(
        .bypass(1'b0), .WINDOW(WINDOW), .MIN_EDGES(MIN_EDGES),
        .MAX_EDGES(MAX_EDGES), .LOCK_WINDOWS(LOCK_WINDOWS)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .fwd_clk(fwd_clk), .enable(enable),
        .active(active), .state_o(state_o), .last_count(last_count),
        .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    fwd_clk_monitor #(
        .bypass(1'b1), .WINDOW(WINDOW), .MIN_EDGES(MIN_EDGES),
        .MAX_EDGES(MAX_EDGES), .LOCK_WINDOWS(LOCK_WINDOWS)
    ) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .fwd_clk(fwd_clk), .enable(enable),
        .active(active_b), .state_o(state_o_b), .last_count(last_count_b),
        .err_pulse(err_pulse_b), .err_sticky(err_sticky_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int div      = 4;
    int ph       = 0;
    int npulse   = 0;
    int npulse_b = 0;

    // Reference model: history of fwd_clk as sampled on each clk edge, plus
    // window bookkeeping in terms of absolute edge numbers
    bit vh [0:VH-1];
    int n    = 0;
    int base = 0;
    int ws   = 0;
    int mst  = 0;
    int good = 0;
    int mlast = 0;
    bit mpulse = 1'b0;
    bit mstk   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit sv(input int k);
        return (k < base) ? 1'b0 : vh[k % VH];
    endfunction

    task automatic model_reset();
        mst = 0; good = 0; mlast = 0; mpulse = 1'b0; mstk = 1'b0; ws = 0;
    endtask

    task automatic model_edge();
        int cnt;
        bit inr;
        vh[n % VH] = fwd_clk;
        mpulse = 1'b0;
        if (!rst_n) begin
            model_reset();
            base = n + 1;
        end else if (!enable) begin
            mst = 0; good = 0; mstk = 1'b0;
        end else if (mst == 0) begin
            mst = 1; good = 0; ws = n + 1;
        end else if (n == ws + WINDOW - 1) begin
            // A rise seen at edge k comes from samples taken at edges k-2 and k-3
            cnt = 0;
            for (int k = ws; k <= n; k++) cnt += int'(sv(k - 2) && !sv(k - 3));
            mlast = cnt;
            inr = (cnt >= MIN_EDGES) && (cnt <= MAX_EDGES);
            ws = n + 1;
            case (mst)
                1: if (inr) begin good++; if (good >= LOCK_WINDOWS) mst = 2; end else good = 0;
                2: if (!inr) begin mst = 3; mpulse = 1'b1; mstk = 1'b1; end
                3: if (inr) begin good = 1; mst = (LOCK_WINDOWS == 1) ? 2 : 1; end
                default: mst = 0;
            endcase
        end
        n++;
    endtask

    task automatic cmp_all();
        chk("state_o",        state_o,      mst);
        chk("active",         active,       mst == 2);
        chk("last_count",     last_count,   mlast);
        chk("err_pulse",      err_pulse,    mpulse);
        chk("err_sticky",     err_sticky,   c_stk & mstk);
        chk("byp_state_o",    state_o_b,    (mst != 0) ? 2 : 0);
        chk("byp_active",     active_b,     mst != 0);
        chk("byp_last_count", last_count_b, mlast);
        chk("byp_err_pulse",  err_pulse_b,  0);
        chk("byp_err_sticky", err_sticky_b, 0);
    endtask

    task automatic drive_fwd();
        fwd_clk = (div == 0) ? 1'b0 : ((ph % div) < (div / 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_all();
        npulse   += int'(err_pulse);
        npulse_b += int'(err_pulse_b);
        ph++;
        drive_fwd();
    endtask

    typedef struct {
        bit en;
        int dv;
        int cyc;
        int st;
        int last;   // -1: count depends on clock phase, not checked
        bit act;
        bit stk;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, len;
        tbl[0] = '{1'b1, 4, 193, 2, 16, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 0, 128, 3,  0, 1'b0, c_stk};
        tbl[2] = '{1'b1, 4,  64, 1, -1, 1'b0, c_stk};
        tbl[3] = '{1'b1, 4, 100, 2, 16, 1'b1, c_stk};
        tbl[4] = '{1'b0, 4,   1, 0, 16, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8, 257, 1,  8, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8,   1, 0,  8, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 3, 257, 1, -1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 3,  20, 1, -1, 1'b0, 1'b0};

        model_reset();
        drive_fwd();
        repeat (4) step();
        rst_n = 1'b1;
        repeat (6) step();

        for (int i = 0; i < 9; i++) begin
            enable = tbl[i].en;
            div    = tbl[i].dv;
            drive_fwd();
            npulse   = 0;
            npulse_b = 0;
            repeat (tbl[i].cyc) step();
            chk($sformatf("row%0d state_o", i), state_o, tbl[i].st);
            chk($sformatf("row%0d active", i), active, tbl[i].act);
            chk($sformatf("row%0d err_sticky", i), err_sticky, tbl[i].stk);
            if (tbl[i].last >= 0)
                chk($sformatf("row%0d last_count", i), last_count, tbl[i].last);
            if (tbl[i].dv == 0) begin
                chk("loss pulse count", npulse, 1);
                chk("bypass pulse count", npulse_b, 0);
                chk("bypass state while stopped", state_o_b, 2);
            end
        end

        // Asynchronous reset in the middle of a window
        chk("pre-reset last_count nonzero", last_count != 0, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst state_o", state_o, 0);
        chk("async rst active", active, 0);
        chk("async rst last_count", last_count, 0);
        chk("async rst err_pulse", err_pulse, 0);
        chk("async rst byp state_o", state_o_b, 0);
        chk("async rst byp active", active_b, 0);
        chk("async rst byp last_count", last_count_b, 0);
        repeat (2) step();
        rst_n = 1'b1;

        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 9);
            enable = (r != 0);
            case ($urandom_range(0, 5))
                0:       div = 0;
                1:       div = 3;
                2:       div = 5;
                3:       div = 8;
                default: div = 4;
            endcase
            len = enable ? $urandom_range(20, 220) : $urandom_range(1, 5);
            drive_fwd();
            repeat (len) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
